// File: rtl/armleocpu_axi_read_arbiter.sv
// Merges the i-cache and d-cache AXI4 masters onto one memory-side master.
// Reads are arbitrated round-robin with one burst in flight; writes pass through from the d-cache.
module armleocpu_axi_read_arbiter #(
  parameter int ADDR_WIDTH = 34,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic [ADDR_WIDTH-1:0]   i_axi_araddr,
  input  logic [7:0]              i_axi_arlen,
  input  logic [2:0]              i_axi_arsize,
  input  logic [1:0]              i_axi_arburst,
  input  logic [ID_WIDTH-1:0]     i_axi_arid,
  input  logic [2:0]              i_axi_arprot,
  input  logic                    i_axi_arlock,
  input  logic                    i_axi_arvalid,
  output logic                    i_axi_arready,
  output logic [DATA_WIDTH-1:0]   i_axi_rdata,
  output logic [1:0]              i_axi_rresp,
  output logic [ID_WIDTH-1:0]     i_axi_rid,
  output logic                    i_axi_rlast,
  output logic                    i_axi_rvalid,
  input  logic                    i_axi_rready,
  input  logic [ADDR_WIDTH-1:0]   i_axi_awaddr,
  input  logic [7:0]              i_axi_awlen,
  input  logic [2:0]              i_axi_awsize,
  input  logic [1:0]              i_axi_awburst,
  input  logic [ID_WIDTH-1:0]     i_axi_awid,
  input  logic [2:0]              i_axi_awprot,
  input  logic                    i_axi_awlock,
  input  logic                    i_axi_awvalid,
  output logic                    i_axi_awready,
  input  logic [DATA_WIDTH-1:0]   i_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_axi_wstrb,
  input  logic                    i_axi_wlast,
  input  logic                    i_axi_wvalid,
  output logic                    i_axi_wready,
  output logic                    i_axi_bvalid,
  output logic [1:0]              i_axi_bresp,
  output logic [ID_WIDTH-1:0]     i_axi_bid,
  input  logic                    i_axi_bready,

  input  logic [ADDR_WIDTH-1:0]   d_axi_araddr,
  input  logic [7:0]              d_axi_arlen,
  input  logic [2:0]              d_axi_arsize,
  input  logic [1:0]              d_axi_arburst,
  input  logic [ID_WIDTH-1:0]     d_axi_arid,
  input  logic [2:0]              d_axi_arprot,
  input  logic                    d_axi_arlock,
  input  logic                    d_axi_arvalid,
  output logic                    d_axi_arready,
  output logic [DATA_WIDTH-1:0]   d_axi_rdata,
  output logic [1:0]              d_axi_rresp,
  output logic [ID_WIDTH-1:0]     d_axi_rid,
  output logic                    d_axi_rlast,
  output logic                    d_axi_rvalid,
  input  logic                    d_axi_rready,
  input  logic [ADDR_WIDTH-1:0]   d_axi_awaddr,
  input  logic [7:0]              d_axi_awlen,
  input  logic [2:0]              d_axi_awsize,
  input  logic [1:0]              d_axi_awburst,
  input  logic [ID_WIDTH-1:0]     d_axi_awid,
  input  logic [2:0]              d_axi_awprot,
  input  logic                    d_axi_awlock,
  input  logic                    d_axi_awvalid,
  output logic                    d_axi_awready,
  input  logic [DATA_WIDTH-1:0]   d_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_axi_wstrb,
  input  logic                    d_axi_wlast,
  input  logic                    d_axi_wvalid,
  output logic                    d_axi_wready,
  output logic                    d_axi_bvalid,
  output logic [1:0]              d_axi_bresp,
  output logic [ID_WIDTH-1:0]     d_axi_bid,
  input  logic                    d_axi_bready,

  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic [ID_WIDTH-1:0]     m_axi_arid,
  output logic [2:0]              m_axi_arprot,
  output logic                    m_axi_arlock,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic [ID_WIDTH-1:0]     m_axi_rid,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic [ID_WIDTH-1:0]     m_axi_awid,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awlock,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic                    m_axi_bvalid,
  input  logic [1:0]              m_axi_bresp,
  input  logic [ID_WIDTH-1:0]     m_axi_bid,
  output logic                    m_axi_bready
);

  typedef enum logic [1:0] {IDLE, I_READ, D_READ} state_t;
  typedef enum logic {GRANT_I, GRANT_D} grant_t;

  state_t state, next_state;
  grant_t last_grant;
  logic   ar_done;
  logic   unused_i_write;

  // Grant bookkeeping; ar_done blocks a second AR once the burst address has been accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GRANT_D;
      ar_done    <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE && next_state == I_READ)
        last_grant <= GRANT_I;
      else if (state == IDLE && next_state == D_READ)
        last_grant <= GRANT_D;
      if (next_state == IDLE)
        ar_done <= 1'b0;
      else if (m_axi_arvalid && m_axi_arready)
        ar_done <= 1'b1;
    end
  end

  always_comb begin
    next_state    = state;
    m_axi_araddr  = i_axi_araddr;
    m_axi_arlen   = i_axi_arlen;
    m_axi_arsize  = i_axi_arsize;
    m_axi_arburst = i_axi_arburst;
    m_axi_arid    = i_axi_arid;
    m_axi_arprot  = i_axi_arprot;
    m_axi_arlock  = i_axi_arlock;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    i_axi_arready = 1'b0;
    i_axi_rdata   = '0;
    i_axi_rresp   = '0;
    i_axi_rid     = '0;
    i_axi_rlast   = 1'b0;
    i_axi_rvalid  = 1'b0;
    d_axi_arready = 1'b0;
    d_axi_rdata   = '0;
    d_axi_rresp   = '0;
    d_axi_rid     = '0;
    d_axi_rlast   = 1'b0;
    d_axi_rvalid  = 1'b0;
    case (state)
      IDLE: begin
        if (i_axi_arvalid && (!d_axi_arvalid || last_grant == GRANT_D))
          next_state = I_READ;
        else if (d_axi_arvalid)
          next_state = D_READ;
      end
      I_READ: begin
        m_axi_arvalid = i_axi_arvalid && !ar_done;
        i_axi_arready = m_axi_arready && !ar_done;
        i_axi_rdata   = m_axi_rdata;
        i_axi_rresp   = m_axi_rresp;
        i_axi_rid     = m_axi_rid;
        i_axi_rlast   = m_axi_rlast;
        i_axi_rvalid  = m_axi_rvalid;
        m_axi_rready  = i_axi_rready;
        if (m_axi_rvalid && i_axi_rready && m_axi_rlast)
          next_state = IDLE;
      end
      D_READ: begin
        m_axi_araddr  = d_axi_araddr;
        m_axi_arlen   = d_axi_arlen;
        m_axi_arsize  = d_axi_arsize;
        m_axi_arburst = d_axi_arburst;
        m_axi_arid    = d_axi_arid;
        m_axi_arprot  = d_axi_arprot;
        m_axi_arlock  = d_axi_arlock;
        m_axi_arvalid = d_axi_arvalid && !ar_done;
        d_axi_arready = m_axi_arready && !ar_done;
        d_axi_rdata   = m_axi_rdata;
        d_axi_rresp   = m_axi_rresp;
        d_axi_rid     = m_axi_rid;
        d_axi_rlast   = m_axi_rlast;
        d_axi_rvalid  = m_axi_rvalid;
        m_axi_rready  = d_axi_rready;
        if (m_axi_rvalid && d_axi_rready && m_axi_rlast)
          next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Only the data cache writes, so the write channels are plain wires
  assign m_axi_awaddr  = d_axi_awaddr;
  assign m_axi_awlen   = d_axi_awlen;
  assign m_axi_awsize  = d_axi_awsize;
  assign m_axi_awburst = d_axi_awburst;
  assign m_axi_awid    = d_axi_awid;
  assign m_axi_awprot  = d_axi_awprot;
  assign m_axi_awlock  = d_axi_awlock;
  assign m_axi_awvalid = d_axi_awvalid;
  assign m_axi_wdata   = d_axi_wdata;
  assign m_axi_wstrb   = d_axi_wstrb;
  assign m_axi_wlast   = d_axi_wlast;
  assign m_axi_wvalid  = d_axi_wvalid;
  assign m_axi_bready  = d_axi_bready;
  assign d_axi_awready = m_axi_awready;
  assign d_axi_wready  = m_axi_wready;
  assign d_axi_bvalid  = m_axi_bvalid;
  assign d_axi_bresp   = m_axi_bresp;
  assign d_axi_bid     = m_axi_bid;

  assign i_axi_awready = 1'b0;
  assign i_axi_wready  = 1'b0;
  assign i_axi_bvalid  = 1'b0;
  assign i_axi_bresp   = '0;
  assign i_axi_bid     = '0;
  assign unused_i_write = ^{i_axi_awaddr, i_axi_awlen, i_axi_awsize, i_axi_awburst, i_axi_awid,
                            i_axi_awprot, i_axi_awlock, i_axi_awvalid, i_axi_wdata, i_axi_wstrb,
                            i_axi_wlast, i_axi_wvalid, i_axi_bready};

endmodule
